// File: rtl/usr_serial_deser.sv
// usr_serial_deser: start/data/stop serial receiver presenting words on a valid/ready port.
// Define USR_DESER_PARITY_EN to add an even-parity bit between the data and the stop bit.
//
// state  | meaning
// IDLE   | line idle, waiting for a start bit (serial_in=0)
// DATA   | shifting in WIDTH data bits
// PARITY | sampling the even-parity bit (USR_DESER_PARITY_EN only)
// STOP   | sampling the stop bit, delivering or discarding the word
module usr_serial_deser #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             res_n,
   input  logic             serial_in,
   input  logic             bit_en,
   output logic [WIDTH-1:0] parallel_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             frame_err,
   output logic             overrun,
   output logic             parity_err
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

`ifdef USR_DESER_PARITY_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_DATA = 2'd1, S_PARITY = 2'd2, S_STOP = 2'd3} state_t;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_DATA = 2'd1, S_STOP = 2'd3} state_t;
`endif

   state_t           state, state_nxt;
   logic [WIDTH-1:0] sr, sr_shift;
   logic [CW-1:0]    cnt;
   logic             par_bad;
   logic             stop_smp, word_done;

   always_comb begin
      state_nxt = state;
      if (bit_en) begin
         case (state)
            S_IDLE:   if (!serial_in) state_nxt = S_DATA;
            S_DATA:
               if (cnt == CNT_LAST) begin
`ifdef USR_DESER_PARITY_EN
                  state_nxt = S_PARITY;
`else
                  state_nxt = S_STOP;
`endif
               end
`ifdef USR_DESER_PARITY_EN
            S_PARITY: state_nxt = S_STOP;
`endif
            S_STOP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
         endcase
      end
   end

   // Shift direction decides which end of the word the first received bit lands in.
   always_comb begin
      sr_shift = sr;
      if (MSB_FIRST) sr_shift = {sr[WIDTH-2:0], serial_in};
      else           sr_shift = {serial_in, sr[WIDTH-1:1]};
   end

   assign stop_smp  = bit_en && (state == S_STOP);
   assign word_done = stop_smp && serial_in && !par_bad;
   assign busy      = (state != S_IDLE);

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state        <= S_IDLE;
         sr           <= '0;
         cnt          <= '0;
         parallel_out <= '0;
         out_valid    <= 1'b0;
         frame_err    <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         state     <= state_nxt;
         frame_err <= 1'b0;
         if (out_valid && out_ready) out_valid <= 1'b0;
         if (bit_en) begin
            case (state)
               S_IDLE: cnt <= '0;
               S_DATA: begin
                  sr  <= sr_shift;
                  cnt <= cnt + CW'(1);
               end
               S_STOP: frame_err <= !serial_in;
               default: ;
            endcase
         end
         // A word completing while the held one is still unaccepted is dropped.
         if (word_done) begin
            if (!out_valid || out_ready) begin
               parallel_out <= sr;
               out_valid    <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end
      end
   end

`ifdef USR_DESER_PARITY_EN
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         par_bad    <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         parity_err <= 1'b0;
         if (bit_en && (state == S_PARITY)) par_bad <= ^sr ^ serial_in;
         if (stop_smp) parity_err <= par_bad;
      end
   end
`else
   assign par_bad    = 1'b0;
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_usr_serial_deser.sv
// Bench for usr_serial_deser: MSB-first and LSB-first instances share one serial line,
// each with its own expected-word queue popped on every output handshake.
module tb_usr_serial_deser;

   logic       clk = 1'b0;
   logic       res_n = 1'b0;
   logic       serial_in = 1'b1;
   logic       bit_en = 1'b0;
   logic       out_ready = 1'b1;
   logic [7:0] po_m, po_l;
   logic       ov_m, ov_l, busy_m, busy_l, fe_m, fe_l, oo_m, oo_l, pe_m, pe_l;

   int         checks = 0;
   int         failures = 0;
   logic [7:0] q_m[$];
   logic [7:0] q_l[$];

   always #5 clk = ~clk;

   usr_serial_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .res_n(res_n), .serial_in(serial_in), .bit_en(bit_en),
      .parallel_out(po_m), .out_valid(ov_m), .out_ready(out_ready), .busy(busy_m),
      .frame_err(fe_m), .overrun(oo_m), .parity_err(pe_m));

   usr_serial_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .res_n(res_n), .serial_in(serial_in), .bit_en(bit_en),
      .parallel_out(po_l), .out_valid(ov_l), .out_ready(out_ready), .busy(busy_l),
      .frame_err(fe_l), .overrun(oo_l), .parity_err(pe_l));

   function automatic logic [7:0] rev8(input logic [7:0] w);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = w[7-i];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (res_n) begin
         if (ov_m && out_ready) begin
            if (q_m.size() == 0) chk("sb_empty_m", 32'(q_m.size()), 32'd1);
            else                 chk("sb_word_m", 32'(po_m), 32'(q_m.pop_front()));
         end
         if (ov_l && out_ready) begin
            if (q_l.size() == 0) chk("sb_empty_l", 32'(q_l.size()), 32'd1);
            else                 chk("sb_word_l", 32'(po_l), 32'(q_l.pop_front()));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   // Gap cycles drive the inverted bit so any sampling without bit_en corrupts the word.
   task automatic drive_bit(input logic b, input int gap);
      for (int i = 1; i < gap; i++) begin
         serial_in = ~b;
         bit_en    = 1'b0;
         @(posedge clk); #1;
      end
      serial_in = b;
      bit_en    = 1'b1;
      @(posedge clk); #1;
      bit_en    = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] w, input logic stop_b, input logic par_b, input int gap);
      drive_bit(1'b0, gap);
      for (int i = 7; i >= 0; i--) drive_bit(w[i], gap);
`ifdef USR_DESER_PARITY_EN
      drive_bit(par_b, gap);
`endif
      drive_bit(stop_b, gap);
   endtask

   task automatic push(input logic [7:0] w);
      q_m.push_back(w);
      q_l.push_back(rev8(w));
   endtask

   task automatic step;
      @(posedge clk); #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_word", 32'(po_m), 32'h0);
      chk("rst_valid", 32'(ov_m), 32'h0);
      chk("rst_busy", 32'(busy_m), 32'h0);
      chk("rst_overrun", 32'(oo_m), 32'h0);
      chk("rst_ferr", 32'(fe_m), 32'h0);
      res_n = 1'b1;
      step();

      push(8'hA5);
      send_frame(8'hA5, 1'b1, ^8'hA5, 1);
      chk("t1_valid", 32'(ov_m), 32'h1);
      chk("t1_word_l", 32'(po_l), 32'(rev8(8'hA5)));
      chk("t1_busy", 32'(busy_m), 32'h0);
      chk("t1_perr", 32'(pe_m), 32'h0);
      step();
      chk("t1_valid_1cyc", 32'(ov_m), 32'h0);

      push(8'hA5);
      send_frame(8'hA5, 1'b1, ^8'hA5, 3);
      chk("t2_valid", 32'(ov_l), 32'h1);
      step();
      push(8'hC1);
      send_frame(8'hC1, 1'b1, ^8'hC1, 3);
      chk("t2_word_m", 32'(po_m), 32'hC1);
      chk("t2_word_l", 32'(po_l), 32'h83);
      step();

      send_frame(8'h3C, 1'b0, ^8'h3C, 1);
      chk("t3_ferr", 32'(fe_m), 32'h1);
      chk("t3_valid", 32'(ov_m), 32'h0);
      step();
      chk("t3_ferr_1cyc", 32'(fe_m), 32'h0);
      push(8'h96);
      send_frame(8'h96, 1'b1, ^8'h96, 1);
      chk("t3_next_valid", 32'(ov_m), 32'h1);

      push(8'h5B);
      push(8'h6D);
      send_frame(8'h5B, 1'b1, ^8'h5B, 1);
      send_frame(8'h6D, 1'b1, ^8'h6D, 1);
      chk("t4_b2b_word", 32'(po_m), 32'h6D);
      chk("t4_b2b_ovr", 32'(oo_m), 32'h0);
      step();

      out_ready = 1'b0;
      push(8'h11);
      send_frame(8'h11, 1'b1, ^8'h11, 1);
      chk("t5_valid", 32'(ov_m), 32'h1);
      chk("t5_ovr0", 32'(oo_m), 32'h0);
      send_frame(8'h22, 1'b1, ^8'h22, 2);
      chk("t5_ovr1", 32'(oo_m), 32'h1);
      chk("t5_hold_m", 32'(po_m), 32'h11);
      chk("t5_hold_l", 32'(po_l), 32'h88);
      chk("t5_valid_hold", 32'(ov_m), 32'h1);
      out_ready = 1'b1;
      step();
      chk("t5_taken", 32'(ov_m), 32'h0);
      chk("t5_sticky", 32'(oo_m), 32'h1);

      out_ready = 1'b0;
      send_frame(8'h5E, 1'b1, ^8'h5E, 1);
      drive_bit(1'b0, 1);
      drive_bit(1'b1, 1);
      drive_bit(1'b1, 1);
      chk("t6_busy_pre", 32'(busy_m), 32'h1);
      #2 res_n = 1'b0;
      #1;
      chk("t6_word", 32'(po_m), 32'h0);
      chk("t6_valid", 32'(ov_m), 32'h0);
      chk("t6_busy", 32'(busy_m), 32'h0);
      chk("t6_overrun", 32'(oo_m), 32'h0);
      chk("t6_ferr", 32'(fe_m), 32'h0);
      chk("t6_perr", 32'(pe_m), 32'h0);
      @(posedge clk); #1;
      chk("t6_ferr_held", 32'(fe_m), 32'h0);
      serial_in = 1'b1;
      out_ready = 1'b1;
      res_n     = 1'b1;
      step();
      push(8'h0F);
      send_frame(8'h0F, 1'b1, ^8'h0F, 1);
      chk("t6_after_valid", 32'(ov_m), 32'h1);
      chk("t6_after_word", 32'(po_m), 32'h0F);
      step();

`ifdef USR_DESER_PARITY_EN
      push(8'h07);
      send_frame(8'h07, 1'b1, 1'b1, 1);
      chk("t7_par_ok_valid", 32'(ov_m), 32'h1);
      chk("t7_par_ok_perr", 32'(pe_m), 32'h0);
      step();
      send_frame(8'h07, 1'b1, 1'b0, 1);
      chk("t7_par_bad_perr", 32'(pe_m), 32'h1);
      chk("t7_par_bad_valid", 32'(ov_m), 32'h0);
      step();
      chk("t7_perr_1cyc", 32'(pe_m), 32'h0);
`endif

      repeat (3) step();
      chk("sb_drain_m", 32'(q_m.size()), 32'h0);
      chk("sb_drain_l", 32'(q_l.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
